// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and freeze controller for a five-stage MIPS pipeline.
// A shadow scoreboard of EX/MEM/WB destinations drives forwards, stalls, flushes and perf counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wr_en,
    input  logic [4:0]       id_wr_addr,
    input  logic             id_is_load,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             freeze,
    output logic [1:0]       ex_fwd_a,
    output logic [1:0]       ex_fwd_b,
    output logic             id_fwd_a,
    output logic             id_fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic       valid;
        logic       wr_en;
        logic [4:0] wr_addr;
        logic       is_load;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
    } slot_t;

    slot_t ex_q, ex_d;
    slot_t mem_q, mem_d;
    slot_t wb_q, wb_d;
    slot_t id_slot;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic stall_evt;
    logic flush_evt;

    // $0 is hardwired to zero, so it never counts as a produced value.
    function automatic logic writes(input slot_t s, input logic [4:0] r);
        return s.valid && s.wr_en && (s.wr_addr == r) && (r != 5'd0);
    endfunction

    function automatic logic [1:0] ex_sel(input logic use_r, input logic [4:0] r,
                                          input slot_t mem_s, input slot_t wb_s);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_r && writes(mem_s, r)) begin
            sel = 2'b01;
        end else if (use_r && writes(wb_s, r)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        id_slot         = '0;
        id_slot.valid   = id_valid;
        id_slot.wr_en   = id_wr_en;
        id_slot.wr_addr = id_wr_addr;
        id_slot.is_load = id_is_load;
        id_slot.rs      = id_rs;
        id_slot.rt      = id_rt;
        id_slot.use_rs  = id_use_rs;
        id_slot.use_rt  = id_use_rt;
    end

    assign load_use = id_valid && ex_q.is_load &&
                      ((id_use_rs && writes(ex_q, id_rs)) ||
                       (id_use_rt && writes(ex_q, id_rt)));

    assign stall_evt = load_use & ~ex_branch_taken & ~mem_busy;
    assign flush_evt = ex_branch_taken & ~mem_busy;

    // Slot advance: freeze holds all, branch/load-use inject a bubble into EX.
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!mem_busy) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (ex_branch_taken || load_use) begin
                ex_d = '0;
            end else begin
                ex_d = id_slot;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_evt && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // While rst is high, only freeze still tracks its input.
    assign freeze      = mem_busy;
    assign stall_if_id = ~rst & (mem_busy | (load_use & ~ex_branch_taken));
    assign flush_if_id = ~rst & flush_evt;
    assign flush_id_ex = ~rst & flush_evt;
    assign ex_fwd_a    = rst ? 2'b00 : ex_sel(ex_q.use_rs, ex_q.rs, mem_q, wb_q);
    assign ex_fwd_b    = rst ? 2'b00 : ex_sel(ex_q.use_rt, ex_q.rt, mem_q, wb_q);
    assign id_fwd_a    = ~rst & id_use_rs & writes(wb_q, id_rs);
    assign id_fwd_b    = ~rst & id_use_rt & writes(wb_q, id_rt);
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expectations.
// Inputs change 1ns after a rising edge; outputs are checked 1ns later.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [4:0]       id_rs, id_rt;
    logic             id_use_rs, id_use_rt;
    logic             id_wr_en;
    logic [4:0]       id_wr_addr;
    logic             id_is_load;
    logic             ex_branch_taken;
    logic             mem_busy;
    logic             stall_if_id, flush_if_id, flush_id_ex, freeze;
    logic [1:0]       ex_fwd_a, ex_fwd_b;
    logic             id_fwd_a, id_fwd_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_pass = 0;
    int n_total = 0;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .freeze(freeze), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
        .id_fwd_a(id_fwd_a), .id_fwd_b(id_fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic urs, input logic urt, input logic wen,
                            input logic [4:0] wa, input logic ld);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_wr_en = wen; id_wr_addr = wa; id_is_load = ld;
    endtask

    task automatic nop();
        drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ex_branch_taken = 1'b0; mem_busy = 1'b0; nop();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_busy = 1'b1; ex_branch_taken = 1'b1;
        drive_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1);
        #2;
        n_total++; if (freeze !== 1'b1) $display("FAIL rst_freeze: got %b want 1", freeze); else n_pass++;
        n_total++; if (stall_if_id !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall_if_id); else n_pass++;
        n_total++; if ({flush_if_id, flush_id_ex} !== 2'b00) $display("FAIL rst_flush: got %b want 00", {flush_if_id, flush_id_ex}); else n_pass++;
        n_total++; if ({ex_fwd_a, ex_fwd_b, id_fwd_a, id_fwd_b} !== 6'b0) $display("FAIL rst_fwd: got %b want 000000", {ex_fwd_a, ex_fwd_b, id_fwd_a, id_fwd_b}); else n_pass++;
        n_total++; if ({stall_cnt, flush_cnt} !== '0) $display("FAIL rst_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); else n_pass++;
        do_reset();
    endtask

    task automatic test_ex_forward();
        do_reset();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);   // add $3,$1,$2
        step();
        drive_id(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);   // sub $4,$3,$5
        step();
        drive_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);   // or $6,$3,$4
        #1;
        n_total++; if (ex_fwd_a !== 2'b01) $display("FAIL fwd_sub_a: got %b want 01", ex_fwd_a); else n_pass++;
        n_total++; if (ex_fwd_b !== 2'b00) $display("FAIL fwd_sub_b: got %b want 00", ex_fwd_b); else n_pass++;
        n_total++; if (stall_if_id !== 1'b0) $display("FAIL fwd_sub_stall: got %b want 0", stall_if_id); else n_pass++;
        step();
        nop();
        #1;
        n_total++; if (ex_fwd_a !== 2'b10) $display("FAIL fwd_or_a: got %b want 10", ex_fwd_a); else n_pass++;
        n_total++; if (ex_fwd_b !== 2'b01) $display("FAIL fwd_or_b: got %b want 01", ex_fwd_b); else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1);   // lw $3,0($1)
        #1;
        n_total++; if (stall_if_id !== 1'b0) $display("FAIL lu_pre_stall: got %b want 0", stall_if_id); else n_pass++;
        step();
        drive_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);   // add $4,$3,$3
        #1;
        n_total++; if (stall_if_id !== 1'b1) $display("FAIL lu_stall: got %b want 1", stall_if_id); else n_pass++;
        n_total++; if ({flush_if_id, flush_id_ex} !== 2'b00) $display("FAIL lu_flush: got %b want 00", {flush_if_id, flush_id_ex}); else n_pass++;
        step();
        #1;
        n_total++; if (stall_if_id !== 1'b0) $display("FAIL lu_one_cycle: got %b want 0", stall_if_id); else n_pass++;
        n_total++; if (stall_cnt !== 4'd1) $display("FAIL lu_cnt: got %0d want 1", stall_cnt); else n_pass++;
        step();
        nop();
        #1;
        n_total++; if ({ex_fwd_a, ex_fwd_b} !== 4'b1010) $display("FAIL lu_fwd: got %b want 1010", {ex_fwd_a, ex_fwd_b}); else n_pass++;
        n_total++; if (stall_cnt !== 4'd1) $display("FAIL lu_cnt_hold: got %0d want 1", stall_cnt); else n_pass++;
    endtask

    task automatic test_id_forward();
        do_reset();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);   // writer $5
        step();
        drive_id(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);
        step();
        drive_id(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 5'd11, 1'b0);
        step();
        drive_id(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 5'd12, 1'b0);  // reader of $5
        #1;
        n_total++; if (id_fwd_a !== 1'b1) $display("FAIL idf_a: got %b want 1", id_fwd_a); else n_pass++;
        n_total++; if (id_fwd_b !== 1'b0) $display("FAIL idf_b: got %b want 0", id_fwd_b); else n_pass++;
        n_total++; if (stall_if_id !== 1'b0) $display("FAIL idf_stall: got %b want 0", stall_if_id); else n_pass++;

        do_reset();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0);   // writer $0
        step();
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd12, 1'b0);
        step();
        drive_id(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);
        #1;
        n_total++; if ({ex_fwd_a, ex_fwd_b} !== 4'b0000) $display("FAIL zero_exfwd: got %b want 0000", {ex_fwd_a, ex_fwd_b}); else n_pass++;
        step();
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd13, 1'b0);
        #1;
        n_total++; if ({id_fwd_a, id_fwd_b} !== 2'b00) $display("FAIL zero_idfwd: got %b want 00", {id_fwd_a, id_fwd_b}); else n_pass++;

        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1);   // lw $0
        step();
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);
        #1;
        n_total++; if (stall_if_id !== 1'b0) $display("FAIL zero_stall: got %b want 0", stall_if_id); else n_pass++;
    endtask

    task automatic test_branch_load_use();
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1);
        step();
        drive_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);
        ex_branch_taken = 1'b1;
        #1;
        n_total++; if ({flush_if_id, flush_id_ex} !== 2'b11) $display("FAIL br_flush: got %b want 11", {flush_if_id, flush_id_ex}); else n_pass++;
        n_total++; if (stall_if_id !== 1'b0) $display("FAIL br_stall: got %b want 0", stall_if_id); else n_pass++;
        step();
        ex_branch_taken = 1'b0;
        nop();
        #1;
        n_total++; if (flush_cnt !== 4'd1) $display("FAIL br_flush_cnt: got %0d want 1", flush_cnt); else n_pass++;
        n_total++; if (stall_cnt !== 4'd0) $display("FAIL br_stall_cnt: got %0d want 0", stall_cnt); else n_pass++;
        n_total++; if (flush_id_ex !== 1'b0) $display("FAIL br_one_cycle: got %b want 0", flush_id_ex); else n_pass++;
    endtask

    task automatic test_freeze();
        do_reset();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0);   // add $7,$1,$2
        step();
        drive_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0);   // addi $9,$7
        step();
        drive_id(1'b1, 5'd9, 5'd7, 1'b1, 1'b1, 1'b1, 5'd10, 1'b0);
        mem_busy = 1'b1;
        ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++; if (freeze !== 1'b1) $display("FAIL frz_freeze[%0d]: got %b want 1", i, freeze); else n_pass++;
            n_total++; if ({flush_if_id, flush_id_ex} !== 2'b00) $display("FAIL frz_flush[%0d]: got %b want 00", i, {flush_if_id, flush_id_ex}); else n_pass++;
            n_total++; if (ex_fwd_a !== 2'b01) $display("FAIL frz_hold[%0d]: got %b want 01", i, ex_fwd_a); else n_pass++;
            step();
        end
        mem_busy = 1'b0;
        #1;
        n_total++; if (freeze !== 1'b0) $display("FAIL frz_release: got %b want 0", freeze); else n_pass++;
        n_total++; if ({flush_if_id, flush_id_ex} !== 2'b11) $display("FAIL frz_late_flush: got %b want 11", {flush_if_id, flush_id_ex}); else n_pass++;
        n_total++; if (flush_cnt !== 4'd0) $display("FAIL frz_cnt_frozen: got %0d want 0", flush_cnt); else n_pass++;
        step();
        ex_branch_taken = 1'b0;
        nop();
        #1;
        n_total++; if (flush_cnt !== 4'd1) $display("FAIL frz_flush_cnt: got %0d want 1", flush_cnt); else n_pass++;
        n_total++; if (ex_fwd_a !== 2'b00) $display("FAIL frz_bubble: got %b want 00", ex_fwd_a); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0);
        step();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0);
        step();
        drive_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);
        step();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1);   // lw $3
        #1;
        n_total++; if ({ex_fwd_a, ex_fwd_b} !== 4'b0101) $display("FAIL b2b_mem_prio: got %b want 0101", {ex_fwd_a, ex_fwd_b}); else n_pass++;
        step();
        drive_id(1'b1, 5'd3, 5'd3, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0);   // does not read $3
        #1;
        n_total++; if (stall_if_id !== 1'b0) $display("FAIL b2b_unused_src: got %b want 0", stall_if_id); else n_pass++;
        drive_id(1'b0, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);   // invalid ID
        #1;
        n_total++; if (stall_if_id !== 1'b0) $display("FAIL b2b_invalid_id: got %b want 0", stall_if_id); else n_pass++;
    endtask

    task automatic test_saturate_and_async_reset();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1);
            step();
            drive_id(1'b1, 5'd3, 5'd2, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);
            step();
        end
        #1;
        n_total++; if (stall_cnt !== 4'd15) $display("FAIL sat_stall_cnt: got %0d want 15", stall_cnt); else n_pass++;
        ex_branch_taken = 1'b1;
        #1 rst = 1'b1;
        #1;
        n_total++; if ({stall_cnt, flush_cnt} !== '0) $display("FAIL async_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); else n_pass++;
        n_total++; if ({stall_if_id, flush_if_id, flush_id_ex} !== 3'b000) $display("FAIL async_out: got %b want 000", {stall_if_id, flush_if_id, flush_id_ex}); else n_pass++;
        #1 rst = 1'b0;
        ex_branch_taken = 1'b0;
        nop();
    endtask

    initial begin
        rst = 1'b1; ex_branch_taken = 1'b0; mem_busy = 1'b0;
        nop();
        test_reset();
        test_ex_forward();
        test_load_use();
        test_id_forward();
        test_branch_load_use();
        test_freeze();
        test_back_to_back();
        test_saturate_and_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard, forwarding and freeze controller for the five-stage MIPS pipeline built around the register file / ALU / PC-mux datapath. It keeps a shadow scoreboard of the destination register of every instruction in EX, MEM and WB. From that scoreboard it drives the forwarding selects, load-use stalls, taken-branch flushes and data-memory freezes. It also keeps saturating stall and flush counters for the debug display.

## Interface
Parameters:
- CNT_W, default 16: width of the performance counters.

Ports:
- clk  input  1: pipeline clock; all state updates on its rising edge.
- rst  input  1: asynchronous, active-high reset.
- id_valid  input  1: the ID stage holds a real instruction.
- id_rs, id_rt  input  5: source register fields of the ID instruction.
- id_use_rs, id_use_rt  input  1: the ID instruction actually reads rs or rt.
- id_wr_en  input  1: the ID instruction writes a register.
- id_wr_addr  input  5: final destination register (after RegDst/Jal muxing, so $31 for jal).
- id_is_load  input  1: the ID instruction is lw.
- ex_branch_taken  input  1: the EX instruction redirects the PC (taken beq/bne, j, jal, jr).
- mem_busy  input  1: data memory is not ready this cycle.
- stall_if_id  output  1: hold PC and the IF/ID register.
- flush_if_id  output  1: load a bubble into IF/ID.
- flush_id_ex  output  1: load a bubble into ID/EX.
- freeze  output  1: hold every pipeline register, including EX/MEM and MEM/WB.
- ex_fwd_a, ex_fwd_b  output  2: ALU operand source for the EX instruction.
  - 00: register file.
  - 01: EX/MEM ALU result.
  - 10: MEM/WB write data.
  - 11: never driven.
- id_fwd_a, id_fwd_b  output  1: at the ID register-read mux, select the WB write data instead of the register file.
- stall_cnt, flush_cnt  output  CNT_W: saturating event counters.

## Operation
Scoreboard:
- Three slots: EX, MEM, WB.
- Each slot holds {valid, wr_en, wr_addr, is_load, rs, rt, use_rs, use_rt}.
- Reset clears every slot, including valid, to 0.

Slot advance, applied each cycle in priority order (first matching rule wins):
1. freeze = 1: all slots hold. Counters increment nothing.
2. ex_branch_taken = 1: EX slot is loaded with a bubble (valid = 0). MEM loads from EX, WB loads from MEM.
3. load_use = 1: EX slot is loaded with a bubble. MEM loads from EX, WB loads from MEM.
4. Otherwise: EX loads the ID fields (valid = id_valid). MEM loads from EX, WB loads from MEM.

Definitions:
- "writes r" means valid && wr_en && wr_addr == r && r != 0.
- load_use = id_valid && EX.is_load && EX writes (id_rs with id_use_rs, or id_rt with id_use_rt).

Combinational outputs:
- freeze = mem_busy.
- stall_if_id = mem_busy | (load_use & ~ex_branch_taken).
- flush_if_id = flush_id_ex = ex_branch_taken & ~mem_busy. A branch held during a freeze is flushed on the first non-busy cycle.
- ex_fwd_a:
  - 01 if EX.use_rs and MEM writes EX.rs.
  - else 10 if WB writes EX.rs.
  - else 00.
  - MEM has priority over WB. ex_fwd_b is the same rule using rt.
- id_fwd_a = id_use_rs && WB writes id_rs. id_fwd_b is the same rule using rt.
- Register $0 never produces a forward, stall or id_fwd.
- A load in MEM never sets ex_fwd = 01 for a consumer in EX. That case cannot occur, because load_use has already inserted a bubble.

Counters:
- stall_cnt increments on every clock where load_use & ~ex_branch_taken & ~mem_busy.
- flush_cnt increments on every clock where flush_id_ex.
- Both saturate at all-ones; they do not wrap.

## Timing
- Reset values: all outputs 0, all counters 0, all slots invalid. With rst high, outputs are 0 regardless of inputs, except freeze, which follows mem_busy.
- All stall, flush and forward outputs are combinational from the current-cycle inputs and slot state, and are valid in the same cycle.
- Load-use costs exactly one stall cycle. On the next edge the load is in MEM and the consumer is still in ID; load_use drops, and the consumer then forwards via 10 in EX.
- Taken branch: one-cycle flush, resolving in EX, which gives a penalty of 2 instructions.
- Branch and load_use asserted together: the branch wins, with no stall and no stall count.
- A freeze held for N cycles keeps all slots unchanged for N edges.
- rst asserted mid-stream clears everything immediately and asynchronously.

## Test plan
- add $3,$1,$2 then sub $4,$3,$5 back-to-back -> in the cycle sub is in EX: ex_fwd_a = 01, no stall.
- lw $3 then add $4,$3,$3 -> exactly one cycle with stall_if_id = 1 and flush_id_ex = 0, and EX gets a bubble. Next cycle: ex_fwd_a = ex_fwd_b = 10. stall_cnt = 1.
- Writer to $5, then two unrelated instructions, then a reader of $5 (the reader is in ID while the writer is in WB) -> id_fwd_a = 1. The same sequence with $0 instead of $5 -> all forwards 0.
- ex_branch_taken = 1 together with a load_use condition -> flush_if_id = flush_id_ex = 1, stall_if_id = 0, flush_cnt = 1, stall_cnt unchanged.
- mem_busy held for 3 cycles with a branch in EX -> freeze = 1 and no flush for 3 cycles, then one flush cycle. Scoreboard unchanged across the freeze.
- Force CNT_W = 4 and generate 20 stalls -> stall_cnt sticks at 15. Pulse rst asynchronously between clock edges -> counters and outputs read 0 immediately.
